// File: rtl/vga_timing_monitor.sv
// ============================================================================
// Module      : vga_timing_monitor
// Description : Passive VGA stream monitor. Samples hsync/vsync/RGB on the
//               pixel strobe and measures line length, hsync width, lines per
//               frame and vsync width against the configured mode. It also
//               checks for black blanking, and declares lock after a run of
//               clean frames.
//               Optional feature macro: VGA_MON_CHECKSUM_EN. When it is
//               defined, a per-frame checksum of the active pixels is
//               reported on frame_sum. Otherwise frame_sum is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_monitor #(
    parameter int COLOR_W     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    input  logic               err_clr,
    output logic               locked,
    output logic               frame_done,
    output logic               err_htotal,
    output logic               err_hsync,
    output logic               err_vtotal,
    output logic               err_vsync,
    output logic               err_blank,
    output logic [15:0]        frame_cnt,
    output logic [31:0]        frame_sum
);

    localparam int C_RGB_W = 3 * COLOR_W;

    // Measurement constants are CNT_W+1 wide. A saturated counter plus one
    // then can never alias a legal total.
    localparam logic [CNT_W:0]   C_H_TOTAL   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [CNT_W:0]   C_V_TOTAL   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [CNT_W:0]   C_H_SYNC_W  = (CNT_W+1)'(H_SYNC);
    localparam logic [CNT_W:0]   C_V_SYNC_W  = (CNT_W+1)'(V_SYNC);
    localparam logic [CNT_W:0]   C_H_ACT_LO  = (CNT_W+1)'(H_SYNC + H_BP);
    localparam logic [CNT_W:0]   C_H_ACT_HI  = (CNT_W+1)'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W:0]   C_V_ACT_LO  = (CNT_W+1)'(V_SYNC + V_BP);
    localparam logic [CNT_W:0]   C_V_ACT_HI  = (CNT_W+1)'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       C_LOCK_FRMS = 4'(LOCK_FRAMES);
    localparam logic             C_SYNC_ACT  = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        ST_SEEK    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Input sampling pipeline: stage 1 holds the pixel under evaluation.
    // Stage 2 holds the previous pixel's sync levels for edge detection.
    logic               hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
    logic               vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
    logic [C_RGB_W-1:0] rgb_q, rgb_d;

    // Position and width counters
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;
    logic [CNT_W-1:0]   vsw_q, vsw_d;

    // Frame qualification state
    state_t             state_q, state_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic               frame_bad_q, frame_bad_d;
    logic               locked_q, locked_d;
    logic               frame_done_q, frame_done_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               err_htotal_q, err_htotal_d;
    logic               err_hsync_q, err_hsync_d;
    logic               err_vtotal_q, err_vtotal_d;
    logic               err_vsync_q, err_vsync_d;
    logic               err_blank_q, err_blank_d;

    // Combinational decode
    logic               w_hs_act, w_hs_prev_act, w_hs_lead, w_hs_trail;
    logic               w_vs_act, w_vs_prev_act, w_vs_lead, w_vs_trail;
    logic [CNT_W-1:0]   w_hpos, w_vpos;
    logic [CNT_W:0]     w_hlen, w_vlen;
    logic               w_in_active;
    logic               w_checking;
    logic               w_err_htotal, w_err_hsync, w_err_vtotal, w_err_vsync, w_err_blank;
    logic [3:0]         w_good_inc;
    logic               w_prev_bad;

    // Edge detection, pixel position and per-tick error detection
    always_comb begin
        w_hs_act      = (hs_s1_q == C_SYNC_ACT);
        w_hs_prev_act = (hs_s2_q == C_SYNC_ACT);
        w_vs_act      = (vs_s1_q == C_SYNC_ACT);
        w_vs_prev_act = (vs_s2_q == C_SYNC_ACT);
        w_hs_lead     = w_hs_act & ~w_hs_prev_act;
        w_hs_trail    = ~w_hs_act & w_hs_prev_act;
        w_vs_lead     = w_vs_act & ~w_vs_prev_act;
        w_vs_trail    = ~w_vs_act & w_vs_prev_act;

        // Position of the stage-1 pixel; the edge pixel itself is position 0
        if (w_hs_lead) begin
            w_hpos = '0;
        end else if (hcnt_q == C_CNT_MAX) begin
            w_hpos = hcnt_q;
        end else begin
            w_hpos = hcnt_q + C_CNT_ONE;
        end

        if (w_vs_lead) begin
            w_vpos = '0;
        end else if (w_hs_lead && (vcnt_q != C_CNT_MAX)) begin
            w_vpos = vcnt_q + C_CNT_ONE;
        end else begin
            w_vpos = vcnt_q;
        end

        // Length of the line or frame that the current edge terminates. The
        // coincident hsync edge closes the last line of the frame.
        w_hlen = (CNT_W+1)'(hcnt_q) + (CNT_W+1)'(1);
        w_vlen = (CNT_W+1)'(vcnt_q) + (CNT_W+1)'(w_hs_lead);

        w_in_active = ((CNT_W+1)'(w_hpos) >= C_H_ACT_LO) && ((CNT_W+1)'(w_hpos) < C_H_ACT_HI) &&
                      ((CNT_W+1)'(w_vpos) >= C_V_ACT_LO) && ((CNT_W+1)'(w_vpos) < C_V_ACT_HI);

        w_checking   = pix_en && (state_q != ST_SEEK);
        w_err_htotal = w_checking && w_hs_lead  && (w_hlen != C_H_TOTAL);
        w_err_hsync  = w_checking && w_hs_trail && (w_hlen != C_H_SYNC_W);
        w_err_vtotal = w_checking && w_vs_lead  && (w_vlen != C_V_TOTAL);
        w_err_vsync  = w_checking && w_vs_trail && ((CNT_W+1)'(vsw_q) != C_V_SYNC_W);
        w_err_blank  = w_checking && !w_in_active && (|rgb_q);

        w_good_inc   = (good_cnt_q == 4'd15) ? good_cnt_q : good_cnt_q + 4'd1;
    end

    // Input pipeline and counters advance only on the pixel strobe
    always_comb begin
        hs_s1_d = hs_s1_q;
        hs_s2_d = hs_s2_q;
        vs_s1_d = vs_s1_q;
        vs_s2_d = vs_s2_q;
        rgb_d   = rgb_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        vsw_d   = vsw_q;
        if (pix_en) begin
            hs_s1_d = hsync;
            hs_s2_d = hs_s1_q;
            vs_s1_d = vsync;
            vs_s2_d = vs_s1_q;
            rgb_d   = {red, green, blue};
            hcnt_d  = w_hpos;
            vcnt_d  = w_vpos;
            // vsync width in lines: hsync edges seen while vsync is asserted
            if (w_vs_lead) begin
                vsw_d = w_hs_lead ? C_CNT_ONE : '0;
            end else if (w_vs_act && w_hs_lead && (vsw_q != C_CNT_MAX)) begin
                vsw_d = vsw_q + C_CNT_ONE;
            end
            // Measurement starts from a clean origin when leaving SEEK
            if ((state_q == ST_SEEK) && w_vs_lead) begin
                hcnt_d = '0;
                vcnt_d = '0;
            end
        end
    end

    // Frame qualification FSM, sticky error flags and frame counting
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        frame_bad_d  = frame_bad_q;
        locked_d     = locked_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        w_prev_bad   = 1'b0;

        // A new error in the same cycle as err_clr leaves the flag set
        err_htotal_d = (err_htotal_q & ~err_clr) | w_err_htotal;
        err_hsync_d  = (err_hsync_q  & ~err_clr) | w_err_hsync;
        err_vtotal_d = (err_vtotal_q & ~err_clr) | w_err_vtotal;
        err_vsync_d  = (err_vsync_q  & ~err_clr) | w_err_vsync;
        err_blank_d  = (err_blank_q  & ~err_clr) | w_err_blank;

        if (pix_en) begin
            case (state_q)
                ST_SEEK: begin
                    if (w_vs_lead) begin
                        state_d     = ST_MEASURE;
                        good_cnt_d  = '0;
                        frame_bad_d = 1'b0;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (w_vs_lead) begin
                        // The line closed by this edge belongs to the ending frame.
                        // The edge pixel belongs to the new frame.
                        w_prev_bad   = frame_bad_q | w_err_htotal | w_err_vtotal |
                                       w_err_hsync | w_err_vsync;
                        frame_done_d = 1'b1;
                        frame_bad_d  = w_err_blank;
                        if (w_prev_bad) begin
                            good_cnt_d = '0;
                            locked_d   = 1'b0;
                            state_d    = ST_MEASURE;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            good_cnt_d  = w_good_inc;
                            if (w_good_inc >= C_LOCK_FRMS) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        frame_bad_d = frame_bad_q | w_err_htotal | w_err_hsync |
                                      w_err_vsync | w_err_blank;
                    end
                end
                default: begin
                    state_d = ST_SEEK;
                end
            endcase
        end
    end

    // State register with synchronous reset; sync pipeline resets to idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1_q      <= ~C_SYNC_ACT;
            hs_s2_q      <= ~C_SYNC_ACT;
            vs_s1_q      <= ~C_SYNC_ACT;
            vs_s2_q      <= ~C_SYNC_ACT;
            rgb_q        <= '0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            vsw_q        <= '0;
            state_q      <= ST_SEEK;
            good_cnt_q   <= '0;
            frame_bad_q  <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_htotal_q <= 1'b0;
            err_hsync_q  <= 1'b0;
            err_vtotal_q <= 1'b0;
            err_vsync_q  <= 1'b0;
            err_blank_q  <= 1'b0;
        end else begin
            hs_s1_q      <= hs_s1_d;
            hs_s2_q      <= hs_s2_d;
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            rgb_q        <= rgb_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            vsw_q        <= vsw_d;
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            frame_bad_q  <= frame_bad_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_htotal_q <= err_htotal_d;
            err_hsync_q  <= err_hsync_d;
            err_vtotal_q <= err_vtotal_d;
            err_vsync_q  <= err_vsync_d;
            err_blank_q  <= err_blank_d;
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic [31:0] frame_sum_q, frame_sum_d;

    // Rotate-and-add checksum over active pixels, published at each frame_done
    always_comb begin
        sum_d       = sum_q;
        frame_sum_d = frame_sum_q;
        if (pix_en && (state_q == ST_SEEK) && w_vs_lead) begin
            sum_d = '0;
        end else if (frame_done_d) begin
            frame_sum_d = sum_q;
            sum_d       = '0;
        end else if (w_checking && w_in_active) begin
            sum_d = {sum_q[30:0], sum_q[31]} + 32'(rgb_q);
        end
    end

    // Checksum registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            sum_q       <= sum_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = 32'd0;
`endif

    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign err_htotal = err_htotal_q;
    assign err_hsync  = err_hsync_q;
    assign err_vtotal = err_vtotal_q;
    assign err_vsync  = err_vsync_q;
    assign err_blank  = err_blank_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire
